// File: rtl/update_sequencer.sv
// Command-burst sequencer for the display write path: paces init and frame-update
// bursts, one write strobe per word, with programmable setup time, pause, abort and a one-deep update queue.
module update_sequencer #(
  parameter int CNT_W     = 9,
  parameter int SETUP_CYC = 1,
  parameter int SETUP_W   = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             init_req,
  input  logic             update_req,
  input  logic [CNT_W-1:0] init_len,
  input  logic [CNT_W-1:0] update_len,
  input  logic             pause,
  input  logic             abort,
  output logic             wr,
  output logic [CNT_W-1:0] word_idx,
  output logic [2:0]       mode,
  output logic             busy,
  output logic             cmd_done,
  output logic             aborted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_I  = 3'd1,
    SEND_I = 3'd2,
    SET_U  = 3'd3,
    SEND_U = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Counter counts down to zero, so SETUP_CYC-1 gives a dwell of SETUP_CYC cycles.
  localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(SETUP_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [SETUP_W-1:0] setup_q, setup_d;
  logic               pend_q, pend_d;
  logic               aborted_q, aborted_d;
  logic               last_word;

  assign last_word = (word_q == len_q - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    len_d     = len_q;
    setup_d   = setup_q;
    pend_d    = pend_q;
    aborted_d = 1'b0;

    // Any update request seen while busy is merged into the single pending slot.
    if (update_req && (state_q != IDLE)) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (init_req) begin
          len_d   = init_len;
          word_d  = '0;
          setup_d = SETUP_LOAD;
          state_d = (init_len == '0) ? DONE : SET_I;
        end else if (update_req || pend_q) begin
          pend_d  = 1'b0;
          len_d   = update_len;
          word_d  = '0;
          setup_d = SETUP_LOAD;
          state_d = (update_len == '0) ? DONE : SET_U;
        end
      end

      SET_I, SET_U: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          pend_d    = 1'b0;
        end else if (!pause) begin
          if (setup_q == '0) state_d = (state_q == SET_I) ? SEND_I : SEND_U;
          else               setup_d = setup_q - SETUP_W'(1);
        end
      end

      SEND_I, SEND_U: begin
        // The strobe in this cycle stands even when abort ends the burst.
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          pend_d    = 1'b0;
        end else if (last_word) begin
          state_d = DONE;
        end else begin
          word_d  = word_q + CNT_W'(1);
          setup_d = SETUP_LOAD;
          state_d = (state_q == SEND_I) ? SET_I : SET_U;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      len_q     <= '0;
      setup_q   <= '0;
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      len_q     <= len_d;
      setup_q   <= setup_d;
      pend_q    <= pend_d;
      aborted_q <= aborted_d;
    end
  end

  // All strobes decode straight from the state register.
  assign mode     = state_q;
  assign wr       = (state_q == SEND_I) || (state_q == SEND_U);
  assign busy     = (state_q != IDLE);
  assign cmd_done = (state_q == DONE);
  assign aborted  = aborted_q;
  assign word_idx = word_q;

endmodule

// File: tb/tb_update_sequencer.sv
// Randomized and directed bench for update_sequencer against a transaction-level burst model.
module tb_update_sequencer;
  localparam int CNT_W     = 9;
  localparam int SETUP_CYC = 1;
  localparam int SETUP_W   = 4;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             init_req = 1'b0, update_req = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [CNT_W-1:0] init_len = '0, update_len = '0;
  logic             wr, busy, cmd_done, aborted;
  logic [CNT_W-1:0] word_idx;
  logic [2:0]       mode;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  update_sequencer #(.CNT_W(CNT_W), .SETUP_CYC(SETUP_CYC), .SETUP_W(SETUP_W)) dut (
    .clk(clk), .nrst(nrst),
    .init_req(init_req), .update_req(update_req),
    .init_len(init_len), .update_len(update_len),
    .pause(pause), .abort(abort),
    .wr(wr), .word_idx(word_idx), .mode(mode), .busy(busy),
    .cmd_done(cmd_done), .aborted(aborted)
  );

  // Burst model: kind 0 none / 1 init / 2 update, words issued, setup cycles left.
  int m_kind, m_len, m_word, m_wait;
  bit m_strobe, m_done, m_abt, m_pend;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_len = 0; m_word = 0; m_wait = 0;
    m_strobe = 0; m_done = 0; m_abt = 0; m_pend = 0;
  endtask

  task automatic model_start(input int kind, input int len);
    if (len == 0) m_done = 1;
    else begin
      m_kind = kind; m_len = len; m_word = 0; m_wait = SETUP_CYC; m_strobe = 0;
    end
  endtask

  task automatic model_step();
    bit abt_n;
    abt_n = 0;
    if (m_done) begin
      m_done = 0;
      if (update_req) m_pend = 1;
    end else if (m_kind == 0) begin
      if (init_req) model_start(1, int'(init_len));
      else if (update_req || m_pend) begin
        m_pend = 0;
        model_start(2, int'(update_len));
      end
    end else begin
      if (update_req) m_pend = 1;
      if (abort) begin
        m_kind = 0; m_strobe = 0; m_pend = 0; abt_n = 1;
      end else if (m_strobe) begin
        m_strobe = 0;
        if (m_word == m_len - 1) begin m_kind = 0; m_done = 1; end
        else begin m_word++; m_wait = SETUP_CYC; end
      end else if (!pause) begin
        m_wait--;
        if (m_wait == 0) m_strobe = 1;
      end
    end
    m_abt = abt_n;
  endtask

  task automatic check_model();
    int exp_mode;
    if (m_done)           exp_mode = 5;
    else if (m_kind == 0) exp_mode = 0;
    else if (m_kind == 1) exp_mode = m_strobe ? 2 : 1;
    else                  exp_mode = m_strobe ? 4 : 3;
    chk("mode", 32'(mode), 32'(exp_mode));
    chk("wr", 32'(wr), 32'(m_strobe));
    chk("busy", 32'(busy), 32'(exp_mode != 0));
    chk("cmd_done", 32'(cmd_done), 32'(m_done));
    chk("aborted", 32'(aborted), 32'(m_abt));
    if (m_strobe) chk("word_idx", 32'(word_idx), 32'(m_word));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the following negedge.
  task automatic cyc(input bit ir, input bit ur, input int il, input int ul, input bit p, input bit a);
    init_req = ir; update_req = ur; init_len = CNT_W'(il); update_len = CNT_W'(ul);
    pause = p; abort = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int k, cnt, t_first, n_wr, n_done;
    bit found;

    model_reset();
    #1;
    chk("rst_mode", 32'(mode), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(cmd_done), 0);
    chk("rst_abt", 32'(aborted), 0);
    chk("rst_idx", 32'(word_idx), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);

    // Init burst, len 3: strobes at 2,4,6 after acceptance, done at 7, idle at 8.
    cyc(1, 0, 3, 0, 0, 0);
    for (k = 1; k <= 8; k++) begin
      if (k > 1) cyc(0, 0, 0, 0, 0, 0);
      chk("d1_wr", 32'(wr), 32'(k == 2 || k == 4 || k == 6));
      if (wr) chk("d1_idx", 32'(word_idx), 32'(k / 2 - 1));
      chk("d1_done", 32'(cmd_done), 32'(k == 7));
      if (k == 8) chk("d1_busy", 32'(busy), 0);
      if (k == 1) chk("d1_mode", 32'(mode), 1);
    end

    // Update len 4, pause for 3 cycles in the second setup phase.
    cyc(0, 1, 0, 4, 0, 0);
    n_wr = 0; n_done = 0; t_first = 0;
    for (k = 1; k <= 16; k++) begin
      if (k > 1) cyc(0, 0, 0, 0, (k - 1) >= 3 && (k - 1) <= 5, 0);
      if (wr) begin
        n_wr++;
        if (n_wr == 2) t_first = k;
      end
      if (cmd_done) n_done++;
    end
    chk("d2_nwr", 32'(n_wr), 4);
    chk("d2_ndone", 32'(n_done), 1);
    chk("d2_t_word1", 32'(t_first), 7);

    // Init and update together; update held -> update burst follows the init burst.
    cyc(1, 1, 2, 3, 0, 0);
    chk("d3_init_first", 32'(mode), 1);
    found = 0; t_first = 0;
    for (k = 2; k <= 20 && !found; k++) begin
      cyc(0, 1, 0, 3, 0, 0);
      if (mode == 3'd3) begin found = 1; t_first = k; end
    end
    chk("d3_upd_start", 32'(t_first), 7);
    repeat (12) cyc(0, 0, 0, 0, 0, 0);

    // Two update pulses during a len-2 burst queue exactly one more burst.
    cyc(0, 1, 0, 2, 0, 0);
    cyc(0, 1, 0, 6, 0, 0);
    cyc(0, 1, 0, 6, 0, 0);
    n_wr = 0; n_done = 0;
    for (k = 4; k <= 25; k++) begin
      cyc(0, 0, 0, 6, 0, 0);
      if (k == 5) chk("d4_done1", 32'(cmd_done), 1);
      if (k == 6) chk("d4_gap", 32'(mode), 0);
      if (k == 7) chk("d4_restart", 32'(mode), 3);
      if (wr && k >= 7) n_wr++;
      if (cmd_done) n_done++;
    end
    chk("d4_nwr2", 32'(n_wr), 6);
    chk("d4_ndone", 32'(n_done), 2);
    chk("d4_idle", 32'(busy), 0);

    // Abort in SET_U at word 5 of 10, then a zero-length update.
    cyc(0, 1, 0, 10, 0, 0);
    found = 0;
    for (cnt = 0; cnt < 40 && !found; cnt++) begin
      if (mode == 3'd3 && word_idx == CNT_W'(5)) found = 1;
      else cyc(0, 0, 0, 0, 0, 0);
    end
    chk("d5_reach", 32'(found), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("d5_mode", 32'(mode), 0);
    chk("d5_aborted", 32'(aborted), 1);
    chk("d5_nodone", 32'(cmd_done), 0);
    for (k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("d5_nowr", 32'(wr), 0);
    end
    cyc(0, 1, 0, 0, 0, 0);
    chk("d5_len0_mode", 32'(mode), 5);
    chk("d5_len0_done", 32'(cmd_done), 1);
    chk("d5_len0_wr", 32'(wr), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("d5_len0_idle", 32'(mode), 0);

    // Async reset while strobing, with an update pending.
    cyc(0, 1, 0, 3, 0, 0);
    cyc(0, 1, 0, 3, 0, 0);
    found = 0;
    for (cnt = 0; cnt < 10 && !found; cnt++) begin
      if (mode == 3'd4) found = 1;
      else cyc(0, 0, 0, 0, 0, 0);
    end
    chk("d6_reach", 32'(found), 1);
    nrst = 1'b0;
    #1;
    chk("d6_mode", 32'(mode), 0);
    chk("d6_wr", 32'(wr), 0);
    chk("d6_busy", 32'(busy), 0);
    chk("d6_idx", 32'(word_idx), 0);
    model_reset();
    #2 nrst = 1'b1;
    for (k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("d6_pend_clr", 32'(busy), 0);
    end

    // Maximum length burst.
    cyc(0, 1, 0, (1 << CNT_W) - 1, 0, 0);
    n_wr = 0;
    for (k = 0; k < 1030; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (wr) n_wr++;
    end
    chk("d7_nwr", 32'(n_wr), 32'((1 << CNT_W) - 1));

    // Random traffic against the model.
    for (k = 0; k < 3000; k++)
      cyc($urandom_range(19) == 0, $urandom_range(5) == 0, $urandom_range(4),
          $urandom_range(5), $urandom_range(3) == 0, $urandom_range(39) == 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/update_sequencer.md
Name: update_sequencer

Overview:
Parametrised command-burst sequencer for the display write path. It drives the write strobe for two burst types: an init sequence and a frame-update sequence.
- Burst length comes from per-request length inputs, replacing a fixed external "finished" signal.
- Setup time before each write is programmable.
- It honours pause back-pressure and supports abort.
- It queues one pending update request while busy.
It sits between the top-level image controller and the pixel/command mux, which uses mode and word_idx to select the data placed on the bus.

Parameters:
CNT_W, 9, width of burst length and word index counters
SETUP_CYC, 1, cycles spent in a SET state before each strobe (>=1)
SETUP_W, 4, width of setup-cycle counter (2^SETUP_W > SETUP_CYC)

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
init_req  in  1  start init burst (level sampled in IDLE)
update_req  in  1  start update burst; pulse while busy is queued
init_len  in  CNT_W  init burst word count, latched on acceptance
update_len  in  CNT_W  update burst word count, latched on acceptance
pause  in  1  stall: hold in SET state, no strobe
abort  in  1  terminate current burst
wr  out  1  write strobe, one cycle per word
word_idx  out  CNT_W  index of current word within burst
mode  out  3  state: 0 IDLE, 1 SET_I, 2 SEND_I, 3 SET_U, 4 SEND_U, 5 DONE
busy  out  1  high in any state except IDLE
cmd_done  out  1  one-cycle pulse on normal burst completion
aborted  out  1  one-cycle pulse when burst ended by abort

Behaviour:
- Reset (nrst low, async):
  - state IDLE; word_idx, length register, setup counter all 0; pending flag 0.
  - Outputs: wr=0, cmd_done=0, aborted=0, busy=0, mode=0.
- IDLE:
  - init_req has priority over update_req and pending.
  - On acceptance, latch the matching len, clear word_idx, load the setup counter, and go to SET_I / SET_U.
  - pending=1 with no init_req: treat as update_req and clear pending.
  - Accepted request with len==0: go directly to DONE, no wr.
- SET_I / SET_U:
  - wr=0.
  - Setup counter decrements only when pause=0.
  - Advance to SEND_x on the cycle the counter reaches 0 with pause=0.
  - Minimum SET dwell is SETUP_CYC cycles; pause extends it cycle-for-cycle.
- SEND_I / SEND_U:
  - wr=1 for exactly one cycle; word_idx is valid for the word being written.
  - If word_idx==len-1: go to DONE.
  - Otherwise word_idx+1, reload the setup counter, return to SET_x.
  - pause is ignored in SEND; a strobe already in SEND completes.
- DONE: cmd_done=1 for one cycle, then go to IDLE.
- Throughput:
  - With pause=0, word n's strobe occurs (SETUP_CYC+1)*(n+1) cycles after the acceptance cycle.
  - Request to cmd_done for length L is L*(SETUP_CYC+1)+1 cycles.
- Abort:
  - Sampled in any SET/SEND state.
  - Next state IDLE, aborted=1 for one cycle, no cmd_done.
  - A wr already asserted this cycle still counts.
  - Abort has priority over advancing.
  - Abort in IDLE/DONE is ignored.
- Pending:
  - update_req while busy sets pending, including update_req during an update.
  - A single-entry flag; further requests are merged.
  - init_req while busy is dropped.
  - Abort also clears pending.
- Counter width:
  - len up to 2^CNT_W-1.
  - word_idx never wraps, because the burst terminates at len-1.
- Other: mode mirrors the state register directly (registered, glitch-free).

Test Plan:
- Reset mid-SEND_U with wr=1 -> all outputs 0, mode=0 asynchronously; pending cleared.
- init_req, init_len=3, SETUP_CYC=1, pause=0 -> wr pulses at cycles 2,4,6 after acceptance with word_idx 0,1,2; mode 1/2 alternating; cmd_done at cycle 7; busy low at 8.
- update_req, update_len=4, pause high 3 cycles during second SET_U -> second wr delayed exactly 3 cycles; total 4 strobes; single cmd_done.
- init_req and update_req asserted together in IDLE -> init burst runs (mode 1/2); update_req held -> update burst starts next after IDLE.
- update_req pulse during update burst of len 2 -> after DONE, one IDLE cycle, then second burst with freshly latched update_len; a second pulse during the same burst still yields only one extra burst.
- abort during SET_U at word_idx=5 of len 10 -> next cycle mode=0, aborted=1, cmd_done=0, no further wr; update_req with len=0 -> DONE next cycle, cmd_done=1, wr never asserted.
